// File: rtl/imem_loader.sv
// Write-side sequencer for the shift-loaded instruction memory: takes DEPTH words over
// valid/ready, drives shift_enable/new_value, then flags done once the image is visible.
// Optional running-XOR checksum port is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 16,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             shift_enable,
  output logic [WIDTH-1:0] new_value,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic             drain_cnt, drain_cnt_next;
  logic             shift_next;
  logic [WIDTH-1:0] new_value_next;
  logic [CNT_W-1:0] word_count_next;
  logic [CNT_W-1:0] count_inc;
  logic             handshake;

  // A word arriving together with abort is not counted: the load is being cancelled.
  assign in_ready  = (state == LOAD);
  assign handshake = in_ready && in_valid && !abort;
  assign busy      = (state == LOAD) || (state == DRAIN);
  assign done      = (state == DONE);
  assign count_inc = word_count + 1'b1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      drain_cnt    <= 1'b0;
      shift_enable <= 1'b0;
      new_value    <= '0;
      word_count   <= '0;
    end else begin
      state        <= state_next;
      drain_cnt    <= drain_cnt_next;
      shift_enable <= shift_next;
      new_value    <= new_value_next;
      word_count   <= word_count_next;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else begin
      checksum <= checksum_next;
    end
  end
`endif

  always_comb begin
    state_next      = state;
    drain_cnt_next  = drain_cnt;
    shift_next      = 1'b0;
    new_value_next  = new_value;
    word_count_next = word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    checksum_next   = checksum;
`endif

    case (state)
      IDLE, DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (start) begin
          state_next      = LOAD;
          word_count_next = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum_next   = '0;
`endif
        end
      end

      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (handshake) begin
          word_count_next = count_inc;
          shift_next      = 1'b1;
          new_value_next  = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum_next   = checksum ^ in_data;
`endif
          if (count_inc == CNT_W'(DEPTH)) begin
            state_next     = DRAIN;
            drain_cnt_next = 1'b0;
          end
        end
      end

      DRAIN: begin
        // First cycle: last shift lands in the array; second: memory output register updates.
        if (abort) begin
          state_next = IDLE;
        end else if (drain_cnt) begin
          state_next = DONE;
        end else begin
          drain_cnt_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader, with a behavioural model of the
// shift-loaded memory (registered flat output) driven by the loader.
module tb_imem_loader;
  localparam int DEPTH = 64;
  localparam int WIDTH = 16;
  localparam int CNT_W = 7;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             shift_enable;
  logic [WIDTH-1:0] new_value;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  int checks;
  int failures;
  int shift_cnt;

  imem_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .shift_enable (shift_enable),
    .new_value    (new_value),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: shift in at index 0, flat output registered one cycle later.
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] data_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_out <= '0;
    end else begin
      if (shift_enable) begin
        for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
        mem[0] <= new_value;
      end
      for (int i = 0; i < DEPTH; i++) data_out[i*WIDTH +: WIDTH] <= mem[i];
    end
  end

  initial shift_cnt = 0;
  always @(posedge clk) if (shift_enable === 1'b1) shift_cnt <= shift_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (word_count !== '0) begin failures++; $display("FAIL reset_word_count: got %0d expected 0", word_count); end
    rst = 1'b0;
    tick();
    // Reset in the middle of a load must clear everything immediately.
    pulse_start();
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    tick();
    tick();
    in_valid = 1'b0;
    checks++; if (word_count !== 7'd2) begin failures++; $display("FAIL midload_count: got %0d expected 2", word_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (word_count !== '0) begin failures++; $display("FAIL async_rst_count: got %0d expected 0", word_count); end
    checks++; if (shift_enable !== 1'b0) begin failures++; $display("FAIL async_rst_shift: got %0b expected 0", shift_enable); end
    checks++; if (new_value !== '0) begin failures++; $display("FAIL async_rst_new_value: got %0h expected 0", new_value); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_rst_flags: got busy=%0b ready=%0b done=%0b expected 0/0/0", busy, in_ready, done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_load();
    pulse_start();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || word_count !== '0) begin failures++; $display("FAIL load_entry: got busy=%0b ready=%0b count=%0d expected 1/1/0", busy, in_ready, word_count); end
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      tick();
      checks++; if (shift_enable !== 1'b1 || new_value !== WIDTH'(i) || word_count !== CNT_W'(i + 1))
        begin failures++; $display("FAIL b2b_word%0d: got shift=%0b value=%0h count=%0d expected 1/%0h/%0d", i, shift_enable, new_value, word_count, i, i + 1); end
    end
    // Excess input: valid stays high with a junk word after the 64th.
    in_data = 16'hFFFF;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL excess_ready: got ready=%0b busy=%0b expected 0/1", in_ready, busy); end
    tick();
    checks++; if (shift_enable !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL drain1: got shift=%0b done=%0b expected 0/0", shift_enable, done); end
    tick();
    in_valid = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL done_rise: got done=%0b busy=%0b expected 1/0", done, busy); end
    checks++; if (word_count !== 7'd64) begin failures++; $display("FAIL done_count: got %0d expected 64", word_count); end
    checks++; if (data_out[1023:1008] !== 16'h0000) begin failures++; $display("FAIL image_top: got %0h expected 0", data_out[1023:1008]); end
    checks++; if (data_out[15:0] !== 16'h003F) begin failures++; $display("FAIL image_bottom: got %0h expected 3f", data_out[15:0]); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++; if (data_out[(DEPTH-1-k)*WIDTH +: WIDTH] !== WIDTH'(k))
        begin failures++; $display("FAIL image_word%0d: got %0h expected %0h", k, data_out[(DEPTH-1-k)*WIDTH +: WIDTH], k); end
    end
    tick();
    checks++; if (done !== 1'b1 || shift_enable !== 1'b0) begin failures++; $display("FAIL done_hold: got done=%0b shift=%0b expected 1/0", done, shift_enable); end
  endtask

  task automatic test_gapped();
    int sent;
    int cyc;
    int s0;
    s0 = shift_cnt;
    pulse_start();
    sent = 0;
    cyc  = 0;
    while (sent < DEPTH) begin
      in_valid = ((cyc % 3) != 1) && ((cyc % 5) != 3);
      in_data  = 16'h2000 + WIDTH'(sent);
      start    = (cyc == 20);
      if (in_valid) sent++;
      tick();
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (done !== 1'b0 || word_count !== 7'd64) begin failures++; $display("FAIL gap_last: got done=%0b count=%0d expected 0/64", done, word_count); end
    tick();
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL gap_done: got %0b expected 1", done); end
    checks++; if (shift_cnt - s0 !== DEPTH) begin failures++; $display("FAIL gap_shift_count: got %0d expected %0d", shift_cnt - s0, DEPTH); end
    checks++; if (data_out[1023:1008] !== 16'h2000) begin failures++; $display("FAIL gap_image_top: got %0h expected 2000", data_out[1023:1008]); end
    checks++; if (data_out[(DEPTH-1-20)*WIDTH +: WIDTH] !== 16'h2014) begin failures++; $display("FAIL gap_image_mid: got %0h expected 2014", data_out[(DEPTH-1-20)*WIDTH +: WIDTH]); end
    checks++; if (data_out[15:0] !== 16'h203F) begin failures++; $display("FAIL gap_image_bottom: got %0h expected 203f", data_out[15:0]); end
  endtask

  task automatic test_abort();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h3000 + WIDTH'(i);
      tick();
    end
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_flags: got busy=%0b ready=%0b done=%0b expected 0/0/0", busy, in_ready, done); end
    checks++; if (word_count !== 7'd10) begin failures++; $display("FAIL abort_count: got %0d expected 10", word_count); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (word_count !== 7'd10 || shift_enable !== 1'b0) begin failures++; $display("FAIL abort_idle_ignore: got count=%0d shift=%0b expected 10/0", word_count, shift_enable); end
    pulse_start();
    checks++; if (word_count !== '0 || busy !== 1'b1) begin failures++; $display("FAIL restart: got count=%0d busy=%0b expected 0/1", word_count, busy); end
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h4000 + WIDTH'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (done !== 1'b1 || word_count !== 7'd64) begin failures++; $display("FAIL restart_done: got done=%0b count=%0d expected 1/64", done, word_count); end
    checks++; if (data_out[1023:1008] !== 16'h4000 || data_out[15:0] !== 16'h403F)
      begin failures++; $display("FAIL restart_image: got top=%0h bottom=%0h expected 4000/403f", data_out[1023:1008], data_out[15:0]); end
  endtask

  task automatic test_start_abort_done();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL sa_precond: got done=%0b expected 1", done); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL sa_flags: got done=%0b busy=%0b ready=%0b expected 0/0/0", done, busy, in_ready); end
    tick();
    checks++; if (busy !== 1'b0 || word_count !== 7'd64) begin failures++; $display("FAIL sa_no_load: got busy=%0b count=%0d expected 0/64", busy, word_count); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    checks++; if (checksum !== '0) begin failures++; $display("FAIL csum_clear: got %0h expected 0", checksum); end
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 16'h1234 : ((i == 1) ? 16'h00FF : 16'h0000);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++; if (done !== 1'b1 || checksum !== 16'h12CB) begin failures++; $display("FAIL csum_done: got done=%0b checksum=%0h expected 1/12cb", done, checksum); end
    in_valid = 1'b1;
    in_data  = 16'h5555;
    tick();
    in_valid = 1'b0;
    checks++; if (checksum !== 16'h12CB) begin failures++; $display("FAIL csum_frozen: got %0h expected 12cb", checksum); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    test_reset();
    test_full_load();
    test_gapped();
    test_abort();
    test_start_abort_done();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
